// File: rtl/hilo_mdu_if.sv
// rtl/hilo_mdu_if.sv - pipeline-side request/response bundle for the HI/LO multiply unit
//
// Purpose: groups the request, hazard and HI/LO read-back signals exchanged
// between the pipeline (master) and hilo_mdu (slave).
//
// Signals:
//   Start   master->slave  request valid this cycle
//   Op      master->slave  3-bit operation code (NOP/MULT/MULTU/MADD/MSUB/MTHI/MTLO)
//   A, B    master->slave  rs / rt operands (A also carries MTHI/MTLO data)
//   ReadHi  master->slave  MFHI in the ALU stage this cycle
//   ReadLo  master->slave  MFLO in the ALU stage this cycle
//   Busy    slave->master  multiply FSM not idle
//   Stall   slave->master  hazard request to the pipeline
//   Done    slave->master  one-cycle pulse after a multiply updates HI/LO
//   Hi_out  slave->master  architectural HI
//   Lo_out  slave->master  architectural LO
interface hilo_mdu_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        ReadHi;
    logic        ReadLo;
    logic        Busy;
    logic        Stall;
    logic        Done;
    logic [31:0] Hi_out;
    logic [31:0] Lo_out;

    modport master (
        output Start, Op, A, B, ReadHi, ReadLo,
        input  Busy, Stall, Done, Hi_out, Lo_out
    );

    modport slave (
        input  Start, Op, A, B, ReadHi, ReadLo,
        output Busy, Stall, Done, Hi_out, Lo_out
    );
endinterface

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - HI/LO register owner with iterative shift-add multiplier
//
// Purpose: holds architectural HI/LO, executes MTHI/MTLO in one cycle and
// MULT/MULTU/MADD/MSUB over N = 32/BITS_PER_CYCLE RUN cycles plus one FIN
// cycle, stalling the pipeline while a multiply is in flight.
//
// Parameters:
//   BITS_PER_CYCLE  multiplier bits retired per RUN cycle (1, 2 or 4)
//
// Ports:
//   Clk    rising-edge clock
//   Reset  asynchronous active-high reset, clears all state
//   bus    hilo_mdu_if.slave: Start/Op/A/B/ReadHi/ReadLo in,
//          Busy/Stall/Done/Hi_out/Lo_out out
//
// Build option:
//   HILO_FORWARD_EN  when defined, Hi_out/Lo_out forward MTHI/MTLO data in the
//                    request cycle and the multiply result in the FIN cycle,
//                    and MFHI/MFLO reads do not stall during FIN.
module hilo_mdu #(
    parameter int BITS_PER_CYCLE = 1
) (
    input logic       Clk,
    input logic       Reset,
    hilo_mdu_if.slave bus
);

    localparam int         N    = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] LAST = 6'(N - 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_MADD  = 3'b011;
    localparam logic [2:0] OP_MSUB  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [63:0] mcand_q;   // multiplicand, shifted left as multiplier bits retire
    logic [31:0] mplier_q;  // multiplier, shifted right so the LSBs are always next
    logic [63:0] prod_q;    // unsigned magnitude product accumulator
    logic        sign_q;
    logic [2:0]  op_q;
    logic [5:0]  cnt_q;
    logic        done_q;

    logic        accept;
    logic        is_mul_op;
    logic        signed_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] step_sum;
    logic [63:0] prod_signed;
    logic [63:0] result;

    assign accept    = bus.Start && (state_q == IDLE);
    assign is_mul_op = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU) ||
                       (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
    assign signed_op = (bus.Op != OP_MULTU);

    // Negating 0x80000000 yields 0x80000000 again, which read as unsigned is
    // exactly the magnitude 2^31, so no special case is needed.
    assign mag_a = (signed_op && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    assign mag_b = (signed_op && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;

    // One RUN iteration: add the multiplicand, shifted by bit position, for each
    // of the next BITS_PER_CYCLE multiplier bits.
    always_comb begin
        step_sum = prod_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_q[k]) begin
                step_sum = step_sum + (mcand_q << k);
            end
        end
    end

    // Final result, valid during FIN; 64-bit arithmetic carries/borrows across
    // the LO/HI boundary and wraps modulo 2^64.
    always_comb begin
        prod_signed = sign_q ? (~prod_q + 64'd1) : prod_q;
        case (op_q)
            OP_MADD: result = {hi_q, lo_q} + prod_signed;
            OP_MSUB: result = {hi_q, lo_q} - prod_signed;
            default: result = prod_signed;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul_op) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            prod_q   <= 64'd0;
            sign_q   <= 1'b0;
            op_q     <= 3'd0;
            cnt_q    <= 6'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        case (bus.Op)
                            OP_MTHI: hi_q <= bus.A;
                            OP_MTLO: lo_q <= bus.A;
                            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                                mcand_q  <= {32'd0, mag_a};
                                mplier_q <= mag_b;
                                prod_q   <= 64'd0;
                                sign_q   <= signed_op && (bus.A[31] ^ bus.B[31]);
                                op_q     <= bus.Op;
                                cnt_q    <= 6'd0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                RUN: begin
                    prod_q   <= step_sum;
                    mcand_q  <= mcand_q << BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> BITS_PER_CYCLE;
                    cnt_q    <= cnt_q + 6'd1;
                end
                FIN: begin
                    {hi_q, lo_q} <= result;
                    done_q       <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Busy = (state_q != IDLE);
    assign bus.Done = done_q;

`ifdef HILO_FORWARD_EN
    // Forwarding lets MFHI/MFLO in the same cycle as MTHI/MTLO, or in FIN,
    // see the value that is about to be written.
    always_comb begin
        bus.Hi_out = hi_q;
        bus.Lo_out = lo_q;
        if (state_q == FIN) begin
            bus.Hi_out = result[63:32];
            bus.Lo_out = result[31:0];
        end else if (accept && (bus.Op == OP_MTHI)) begin
            bus.Hi_out = bus.A;
        end else if (accept && (bus.Op == OP_MTLO)) begin
            bus.Lo_out = bus.A;
        end
    end

    assign bus.Stall = bus.Busy &&
                       (bus.Start || ((bus.ReadHi || bus.ReadLo) && (state_q != FIN)));
`else
    assign bus.Hi_out = hi_q;
    assign bus.Lo_out = lo_q;
    assign bus.Stall  = bus.Busy && (bus.Start || bus.ReadHi || bus.ReadLo);
`endif

endmodule
